lsu_mem_ctrl: RTL and testbench

//  - Load/store controller sitting directly upstream of the word-wide dual-port data RAM (1-cycle sync read, same-address write bypass inside RAM).
//  - Converts core byte/half/word load-store requests into word RAM accesses.
//  - Sub-word stores use read-modify-write (RMW).
//  - Loads return sign/zero-extended data over a valid/ready response handshake.

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_mem_ctrl_if.sv | 53 +++++
 rtl/lsu_byte_lane.sv | 50 +++++
 rtl/lsu_mem_ctrl.sv | 165 ++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store controller: access-size
// encodings, controller state enum, byte-lane width and lane alignment helpers.
package lsu_pkg;

    localparam int LANE_W = 8;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_R = 2'b11   // reserved, behaves as a word access
    } size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WAIT = 2'b01,
        RSP     = 2'b10
    } state_e;

    // Word and the reserved encoding both have bit 1 set.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    // Lane of the first addressed byte, with low bits cleared to the size boundary.
    function automatic logic [1:0] align_lane(input logic [1:0] size, input logic [1:0] lo);
        logic [1:0] lane;
        case (size)
            SZ_B:    lane = lo;
            SZ_H:    lane = {lo[1], 1'b0};
            default: lane = 2'b00;
        endcase
        return lane;
    endfunction

    // True when the byte address is not a multiple of the access size.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = lo[0];
            default: mis = |lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Bundle of the core request/response handshake and the data-RAM port of
// lsu_mem_ctrl. The optional rsp_err signal exists only when
// LSU_MISALIGN_ERR_EN is defined.
interface lsu_mem_ctrl_if #(
    parameter int AW   = 12,
    parameter int XLEN = 32
);
    // core request
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    // core response
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
`ifdef LSU_MISALIGN_ERR_EN
    logic            rsp_err;
`endif
    // data RAM
    logic            ram_r_en;
    logic [AW-1:0]   ram_r_addr;
    logic [XLEN-1:0] ram_r_data;
    logic            ram_w_en;
    logic [AW-1:0]   ram_w_addr;
    logic [XLEN-1:0] ram_w_data;

    // Environment view: the core plus the RAM.
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_ready, ram_r_data,
`ifdef LSU_MISALIGN_ERR_EN
        input  rsp_err,
`endif
        input  req_ready, rsp_valid, rsp_rdata,
        input  ram_r_en, ram_r_addr, ram_w_en, ram_w_addr, ram_w_data
    );

    // Controller view.
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_ready, ram_r_data,
`ifdef LSU_MISALIGN_ERR_EN
        output rsp_err,
`endif
        output req_ready, rsp_valid, rsp_rdata,
        output ram_r_en, ram_r_addr, ram_w_en, ram_w_addr, ram_w_data
    );

endinterface

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering for the load/store controller. Purely combinational:
// extracts and sign/zero-extends the addressed byte/half of a RAM word for
// loads, and merges right-aligned store data into a RAM word for sub-word
// stores. lane_i is expected already aligned to the access size.
module lsu_byte_lane
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [1:0]      size_i,
    input  logic [1:0]      lane_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] load_o,
    output logic [XLEN-1:0] merge_o
);

    localparam int HALF_W = 2 * LANE_W;

    logic [LANE_W-1:0] byte_sel;
    logic [HALF_W-1:0] half_sel;
    logic              byte_sign;
    logic              half_sign;

    // Select the addressed lane, extend it for loads and splice it in for stores.
    always_comb begin
        byte_sel  = word_i[{lane_i, 3'b000} +: LANE_W];
        half_sel  = word_i[{lane_i[1], 4'b0000} +: HALF_W];
        byte_sign = ~unsigned_i & byte_sel[LANE_W-1];
        half_sign = ~unsigned_i & half_sel[HALF_W-1];
        load_o    = word_i;
        merge_o   = word_i;
        case (size_i)
            SZ_B: begin
                load_o = {{(XLEN-LANE_W){byte_sign}}, byte_sel};
                merge_o[{lane_i, 3'b000} +: LANE_W] = data_i[LANE_W-1:0];
            end
            SZ_H: begin
                load_o = {{(XLEN-HALF_W){half_sign}}, half_sel};
                merge_o[{lane_i[1], 4'b0000} +: HALF_W] = data_i[HALF_W-1:0];
            end
            default: begin
                load_o  = word_i;
                merge_o = data_i;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a word-wide dual-port data RAM with a
// 1-cycle synchronous read. Byte/half/word requests become word accesses;
// sub-word stores are read-modify-write; loads are extended and returned over
// a valid/ready response. One transaction in flight at a time.
// Optional feature macro: LSU_MISALIGN_ERR_EN (misaligned requests answer with
// rsp_err instead of being force-aligned).
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int AW   = 12,
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    lsu_mem_ctrl_if.slave  bus
);

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [1:0]      lane_q, lane_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef LSU_MISALIGN_ERR_EN
    logic            rsp_err_q, rsp_err_d;
    logic            req_mis;
`endif

    logic            accept;
    logic [AW-1:0]   req_idx;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merged;
    logic            ram_r_en;
    logic            ram_w_en;
    logic [AW-1:0]   ram_w_addr;
    logic [XLEN-1:0] ram_w_data;
    logic            unused_addr_hi;

    // Address bits above the RAM word index wrap away.
    assign req_idx        = bus.req_addr[AW+1:2];
    assign unused_addr_hi = ^bus.req_addr[XLEN-1:AW+2];
`ifdef LSU_MISALIGN_ERR_EN
    assign req_mis        = misaligned(bus.req_size, bus.req_addr[1:0]);
`endif

    // No request is taken while reset is asserted, so the RAM stays idle then.
    assign accept = bus.req_valid & (state_q == IDLE) & ~rst;

    lsu_byte_lane #(.XLEN(XLEN)) u_lane (
        .word_i     (bus.ram_r_data),
        .data_i     (wdata_q),
        .size_i     (size_q),
        .lane_i     (lane_q),
        .unsigned_i (uns_q),
        .load_o     (load_data),
        .merge_o    (merged)
    );

    // Next-state, request latching and RAM port control.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lane_d      = lane_q;
        size_d      = size_q;
        uns_d       = uns_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef LSU_MISALIGN_ERR_EN
        rsp_err_d   = rsp_err_q;
`endif
        ram_r_en    = 1'b0;
        ram_w_en    = 1'b0;
        ram_w_addr  = idx_q;
        ram_w_data  = merged;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d       = req_idx;
                    lane_d      = align_lane(bus.req_size, bus.req_addr[1:0]);
                    size_d      = bus.req_size;
                    uns_d       = bus.req_unsigned;
                    we_d        = bus.req_we;
                    wdata_d     = bus.req_wdata;
                    rsp_rdata_d = '0;
`ifdef LSU_MISALIGN_ERR_EN
                    rsp_err_d   = 1'b0;
                    if (req_mis) begin
                        rsp_err_d = 1'b1;
                        state_d   = RSP;
                    end else
`endif
                    if (bus.req_we && is_word(bus.req_size)) begin
                        // Full-word store goes straight to the RAM.
                        ram_w_en   = 1'b1;
                        ram_w_addr = req_idx;
                        ram_w_data = bus.req_wdata;
                        state_d    = RSP;
                    end else begin
                        // Loads and sub-word stores need the current word first.
                        ram_r_en = 1'b1;
                        state_d  = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (we_q) begin
                    // Write-back of the merged word; suppressed if reset hits now.
                    ram_w_en = ~rst;
                end else begin
                    rsp_rdata_d = load_data;
                end
                state_d = RSP;
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rsp_rdata_q <= '0;
`ifdef LSU_MISALIGN_ERR_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef LSU_MISALIGN_ERR_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    // Latched request fields; only meaningful while a transaction is open.
    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        lane_q  <= lane_d;
        size_q  <= size_d;
        uns_q   <= uns_d;
        we_q    <= we_d;
        wdata_q <= wdata_d;
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.rsp_valid  = (state_q == RSP);
    assign bus.rsp_rdata  = rsp_rdata_q;
`ifdef LSU_MISALIGN_ERR_EN
    assign bus.rsp_err    = rsp_err_q;
`endif
    assign bus.ram_r_en   = ram_r_en;
    assign bus.ram_r_addr = req_idx;
    assign bus.ram_w_en   = ram_w_en;
    assign bus.ram_w_addr = ram_w_addr;
    assign bus.ram_w_data = ram_w_data;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: table of directed vectors, hand-written
// handshake/reset/wrap/misalignment sequences, and randomized traffic checked
// against a byte-array memory model.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    localparam int AW   = 12;
    localparam int XLEN = 32;
    localparam int NW   = 1 << AW;
    localparam int NB   = 4 * NW;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic fill = 1'b0;

    always #5 clk = ~clk;

    lsu_mem_ctrl_if #(.AW(AW), .XLEN(XLEN)) bus();

    lsu_mem_ctrl #(.AW(AW), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- data RAM: 1-cycle read, write bypass on same address
    logic [31:0] ram_mem [NW];
    logic [31:0] ram_rd_q;

    function automatic logic [31:0] pat(input int i);
        logic [31:0] ii;
        ii = i;
        return (ii * 32'h9E3779B1) ^ 32'h5A5AA5A5;
    endfunction

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < NW; i++) ram_mem[i] <= pat(i);
        end else begin
            if (bus.ram_w_en) ram_mem[bus.ram_w_addr] <= bus.ram_w_data;
            if (bus.ram_r_en)
                ram_rd_q <= (bus.ram_w_en && bus.ram_w_addr == bus.ram_r_addr)
                            ? bus.ram_w_data : ram_mem[bus.ram_r_addr];
        end
    end
    assign bus.ram_r_data = ram_rd_q;

    // ---------------- reference model: flat byte memory
    logic [7:0] ref_bytes [NB];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        return 4;
    endfunction

    task automatic model_op(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output int lat, output logic err);
        int nb;
        int a;
        int base;
        logic [31:0] v;
        nb  = nbytes(sz);
        a   = int'(addr % NB);
        err = 1'b0;
        rd  = 32'h0;
        lat = 2;
`ifdef LSU_MISALIGN_ERR_EN
        if (a % nb != 0) begin
            err = 1'b1;
            lat = 1;
            return;
        end
`endif
        base = a - (a % nb);
        if (we) begin
            for (int i = 0; i < nb; i++) ref_bytes[base + i] = 8'((wd >> (8 * i)) & 32'hFF);
            lat = (nb == 4) ? 1 : 2;
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_bytes[base + i]) << (8 * i));
            if (!uns && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFFFFFF << (8 * nb));
            rd = v;
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
    endfunction

    // Called at a negedge with the controller idle; returns at a negedge, idle again.
    task automatic run_op(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat, output logic ren_t,
                          output logic wen_t, output logic [AW-1:0] raddr_t, output logic err);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        #1;
        ren_t   = bus.ram_r_en;
        wen_t   = bus.ram_w_en;
        raddr_t = bus.ram_r_addr;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        rd  = bus.rsp_rdata;
        err = 1'b0;
`ifdef LSU_MISALIGN_ERR_EN
        err = bus.rsp_err;
`endif
        @(negedge clk);
    endtask

    task automatic check_op(input string name, input logic we, input logic [1:0] sz,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] erd, ard;
        int elat, alat;
        logic eerr, aerr, ren, wen;
        logic [AW-1:0] ra;
        model_op(we, sz, uns, addr, wd, erd, elat, eerr);
        run_op(we, sz, uns, addr, wd, ard, alat, ren, wen, ra, aerr);
        chk({name, "_rdata"}, ard, erd);
        chk({name, "_lat"}, 32'(alat), 32'(elat));
`ifdef LSU_MISALIGN_ERR_EN
        chk({name, "_err"}, 32'(aerr), 32'(eerr));
`endif
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_lat;
        logic        exp_ren;
        logic        exp_wen;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, erd, v0;
        int lat, elat;
        logic ren, wen, err, eerr;
        logic [AW-1:0] ra;

        vecs[0]  = '{1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, SZ_W, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 2, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, SZ_W, 1'b0, 32'h10, 32'h11223344, 32'h0,        1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, SZ_B, 1'b0, 32'h11, 32'h000000AA, 32'h0,        2, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, SZ_W, 1'b0, 32'h10, 32'h0,        32'h1122AA44, 2, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, SZ_B, 1'b0, 32'h11, 32'h0,        32'hFFFFFFAA, 2, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, SZ_B, 1'b1, 32'h11, 32'h0,        32'h000000AA, 2, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, SZ_W, 1'b0, 32'h10, 32'h11223344, 32'h0,        1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, SZ_H, 1'b0, 32'h12, 32'h00008001, 32'h0,        2, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, SZ_W, 1'b0, 32'h10, 32'h0,        32'h80013344, 2, 1'b1, 1'b0};
        vecs[10] = '{1'b0, SZ_H, 1'b0, 32'h12, 32'h0,        32'hFFFF8001, 2, 1'b1, 1'b0};
        vecs[11] = '{1'b0, SZ_H, 1'b1, 32'h12, 32'h0,        32'h00008001, 2, 1'b1, 1'b0};
        vecs[12] = '{1'b0, SZ_B, 1'b0, 32'h13, 32'h0,        32'hFFFFFF80, 2, 1'b1, 1'b0};
        vecs[13] = '{1'b1, SZ_R, 1'b0, 32'h40, 32'hCAFEF00D, 32'h0,        1, 1'b0, 1'b1};
        vecs[14] = '{1'b0, SZ_R, 1'b0, 32'h40, 32'h0,        32'hCAFEF00D, 2, 1'b1, 1'b0};

        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = SZ_W;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.rsp_ready    = 1'b1;
        fill             = 1'b1;
        for (int i = 0; i < NW; i++)
            for (int b = 0; b < 4; b++) ref_bytes[4*i+b] = 8'(pat(i) >> (8 * b));

        // ---------------- reset: a request offered during reset is ignored
        @(negedge clk);
        fill          = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h12345678;
        #1;
        chk("rst_ram_w_en", 32'(bus.ram_w_en), 32'h0);
        chk("rst_ram_r_en", 32'(bus.ram_r_en), 32'h0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst           = 1'b0;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
`ifdef LSU_MISALIGN_ERR_EN
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
`endif
        chk("rst_no_write", ram_mem[0], pat(0));
        @(negedge clk);

        // ---------------- directed vector table
        for (int i = 0; i < 15; i++) begin
            model_op(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, erd, elat, eerr);
            run_op(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, rd, lat, ren, wen, ra, err);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_ren_T", i), 32'(ren), 32'(vecs[i].exp_ren));
            chk($sformatf("vec%0d_wen_T", i), 32'(wen), 32'(vecs[i].exp_wen));
        end
        chk("vec_ram_word4", ram_mem[4], 32'h80013344);

        // ---------------- response held off for 3 cycles, then back-to-back request
        model_op(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, erd, elat, eerr);
        bus.rsp_ready    = 1'b0;
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b0;
        bus.req_size     = SZ_W;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h10;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("hold_lat", 32'(lat), 32'd2);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h44;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("hold%0d_rsp_valid", k), 32'(bus.rsp_valid), 32'h1);
            chk($sformatf("hold%0d_rsp_rdata", k), bus.rsp_rdata, erd);
            chk($sformatf("hold%0d_req_ready", k), 32'(bus.req_ready), 32'h0);
            chk($sformatf("hold%0d_ram_r_en", k), 32'(bus.ram_r_en), 32'h0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("hold_next_req_ready", 32'(bus.req_ready), 32'h1);
        chk("hold_next_ram_r_en", 32'(bus.ram_r_en), 32'h1);
        chk("hold_next_ram_r_addr", 32'(bus.ram_r_addr), 32'h11);
        model_op(1'b0, SZ_W, 1'b0, 32'h44, 32'h0, erd, elat, eerr);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("hold_next_rdata", bus.rsp_rdata, erd);
        @(negedge clk);

        // ---------------- reset during RD_WAIT of a byte store
        check_op("rstmid_pre", 1'b1, SZ_W, 1'b0, 32'h20, 32'h01020304);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = SZ_B;
        bus.req_addr     = 32'h21;
        bus.req_wdata    = 32'h000000EE;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst           = 1'b1;
        #1;
        chk("rstmid_ram_w_en", 32'(bus.ram_w_en), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rstmid_req_ready", 32'(bus.req_ready), 32'h1);
        chk("rstmid_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rstmid_ram_word", ram_mem[8], 32'h01020304);
        @(negedge clk);
        check_op("rstmid_load", 1'b0, SZ_W, 1'b0, 32'h20, 32'h0);

        // ---------------- address wrap
        model_op(1'b0, SZ_W, 1'b0, 32'hFFFF0004, 32'h0, erd, elat, eerr);
        run_op(1'b0, SZ_W, 1'b0, 32'hFFFF0004, 32'h0, rd, lat, ren, wen, ra, err);
        chk("wrap_ram_r_addr", 32'(ra), 32'h1);
        chk("wrap_rdata", rd, erd);

        // ---------------- misalignment
`ifdef LSU_MISALIGN_ERR_EN
        run_op(1'b0, SZ_W, 1'b0, 32'h2, 32'h0, rd, lat, ren, wen, ra, err);
        chk("mis_ld_err", 32'(err), 32'h1);
        chk("mis_ld_rdata", rd, 32'h0);
        chk("mis_ld_ram_r_en", 32'(ren), 32'h0);
        chk("mis_ld_lat", 32'(lat), 32'h1);
        run_op(1'b1, SZ_H, 1'b0, 32'h13, 32'h0000BEEF, rd, lat, ren, wen, ra, err);
        chk("mis_st_err", 32'(err), 32'h1);
        chk("mis_st_ram_en", 32'({ren, wen}), 32'h0);
        check_op("mis_after", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
`else
        check_op("mis_ld_word", 1'b0, SZ_W, 1'b0, 32'h12, 32'h0);
        check_op("mis_st_half", 1'b1, SZ_H, 1'b0, 32'h13, 32'h0000BEEF);
        check_op("mis_after", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
        chk("mis_ram_word4", ram_mem[4], 32'hBEEF3344);
`endif

        // ---------------- randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFFC000) | 32'($urandom_range(0, 63));
            check_op($sformatf("rnd%0d", i), 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
        end
        for (int w = 0; w < 16; w++) chk($sformatf("final_word%0d", w), ram_mem[w], ref_word(w));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
